// File: rtl/alu_issue_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_issue_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface alu_issue_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_data;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready, alu_data,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        output alu_data1, alu_data2, alu_ctrl, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready, alu_data,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        input  alu_data1, alu_data2, alu_ctrl, busy
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Shares one single-cycle ALU between two requesters with round-robin grant.
// Operands are held for MUL_CYCLES on multiply, and the result is returned on a tagged response.
module alu_issue_arbiter #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    alu_issue_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [2:0] OpMul   = 3'b100;
    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        id_q, id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;

    logic gnt_valid;
    logic gnt_id;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == StIdle) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant_q;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // Ready is masked while reset is held so that every output reads zero in reset.
    assign bus.req0_ready = rst_i && gnt_valid && !gnt_id;
    assign bus.req1_ready = rst_i && gnt_valid && gnt_id;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    op_d    = gnt_id ? bus.req1_op : bus.req0_op;
                    a_d     = gnt_id ? bus.req1_a : bus.req0_a;
                    b_d     = gnt_id ? bus.req1_b : bus.req0_b;
                    id_d    = gnt_id;
                    cnt_d   = (op_d == OpMul) ? MulLoad : 4'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d = bus.alu_data;
                    rsp_id_d   = id_q;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= 3'b000;
            id_q         <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign bus.alu_data1 = a_q;
    assign bus.alu_data2 = b_q;
    assign bus.alu_ctrl  = op_q;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Sequencing and arbitration controller that shares the single-cycle ALU between two requesters (e.g. the main issue path and an address/helper path). It accepts an operation with a valid/ready handshake, round-robins between requesters, and drives the ALU operand and control inputs from internal registers. It holds them stable for a programmable number of cycles on multiply, then returns the captured result on a registered response channel tagged with the requester id.

## Interface
- MUL_CYCLES, 3: cycles ALU inputs are held for a multiply (ALUCtrl 3'b100); legal range 1..15.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 operation accepted this cycle.
- req0_op_i  in  3  ALUCtrl code (010 add, 100 mul, 110 sub, 000 and, 001 or).
- req0_a_i, req0_b_i  in  32  operands (a becomes data1, b becomes data2).
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i: as requester 0.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_id_o  out  1  requester that owns the response.
- rsp_data_o  out  32  captured ALU result.
- alu_data1_o, alu_data2_o  out  32  to ALU data1_i / data2_i.
- alu_ctrl_o  out  3  to ALU ALUCtrl_i.
- alu_data_i  in  32  from ALU data_o.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP. The block has one operation in flight at most.
- Grant (combinational, IDLE only):
  - Both valid: grant the requester that is not `last_grant`.
  - One valid: grant that requester.
  - None valid: no grant.
- reqN_ready_o = (state == IDLE) && grant == N. It is low in EXEC and RESP. It may depend combinationally on reqN_valid_i.
- IDLE:
  - Acceptance is valid && ready.
  - On acceptance, latch op, a, b and id into op_r, a_r, b_r and id_r.
  - Load cnt = MUL_CYCLES-1 if op is 3'b100, else 0. Go to EXEC.
- EXEC:
  - alu_data1_o = a_r, alu_data2_o = b_r, alu_ctrl_o = op_r.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture alu_data_i into rsp_data_o, set rsp_id_o = id_r, and go to RESP.
- RESP:
  - rsp_valid_o = 1.
  - On rsp_ready_i, set last_grant = id_r, drop rsp_valid_o and go to IDLE. A new request is not accepted in the same cycle.
- ALU outputs always reflect a_r, b_r and op_r, so they stay stable between operations.
- Unknown op codes are passed through unchanged with latency 1; the ALU defaults them to AND.
- rsp_data_o and rsp_id_o hold their value after the response until the next capture.
- Widths: the result is the full 32-bit ALU output; a mul product keeps its low 32 bits only, with no overflow flag. The ALU zero flag is not used.

## Timing
- Reset (rst_i low, asynchronous) clears:
  - state to IDLE, cnt = 0, last_grant = 1 (requester 0 wins the first tie);
  - a_r, b_r, op_r, id_r = 0;
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_id_o = 0, busy_o = 0;
  - alu_data1_o = alu_data2_o = 0, alu_ctrl_o = 3'b000.
- Reset during EXEC or RESP discards the operation and produces no response. After rst_i rises, the first grant follows the reset-time priority.
- Latency: let L = MUL_CYCLES for mul, else 1. With acceptance at edge k, EXEC occupies cycles k..k+L-1 and rsp_valid_o rises at edge k+L.
- With rsp_ready_i high, RESP lasts exactly 1 cycle. Peak throughput is one operation per L+2 cycles.
- Backpressure: RESP persists indefinitely. rsp_valid_o, rsp_data_o and rsp_id_o stay stable, and both ready outputs stay low.
- Requester-side rule: a requester keeps valid and its payload stable until it sees ready. Changes before acceptance are allowed and are sampled only at the accepting edge.

## Test plan
- Reset: hold rst_i low with random inputs -> all outputs 0. Release with both valid -> req0_ready_o = 1, req1_ready_o = 0.
- Add: req0 op 010, a = 5, b = 7, accepted at edge k -> alu_ctrl_o = 010 during cycle k; rsp_valid_o at edge k+1 with rsp_data_o = 12, rsp_id_o = 0.
- Multiply: MUL_CYCLES = 3, req1 op 100, a = 6, b = 7 -> ALU inputs stable for 3 cycles, busy_o high, rsp_data_o = 42, rsp_id_o = 1 at edge k+3. Also a = 32'h0001_0000, b = 32'h0001_0000 -> 0.
- Fairness: both requesters valid continuously with rsp_ready_i = 1 -> grant order 0, 1, 0, 1. A sub 10−3 on req0 returns 7; an or 0xF0|0x0F on req1 returns 0xFF.
- Backpressure: rsp_ready_i low for 4 cycles in RESP -> response held unchanged, both ready outputs low, no second acceptance. Accepted on the 5th cycle.
- Mid-operation reset: assert rst_i in the 2nd EXEC cycle of a mul -> no rsp_valid_o. After release, req0 add 1 + 1 returns 2.
